// File: rtl/rom_word_splitter_pipe.sv
`default_nettype none
// ============================================================================
// Module  : rom_word_splitter_pipe
// Brief   : Registered valid/ready splitter of multi-bank ROM words into
//           parallel lanes or per-bank serial sub-word beats (MSB first).
// Revision: 1.0
// ============================================================================
module rom_word_splitter_pipe #(
  parameter int BANKS   = 2,
  parameter int D_WIDTH = 64,
  parameter int SPLIT   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BANKS*SPLIT*D_WIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BANKS*SPLIT*D_WIDTH-1:0]   out_par,
  output logic [BANKS*D_WIDTH-1:0]         out_ser,
  output logic [$clog2(SPLIT)-1:0]         out_idx,
  output logic                             out_last
);

  localparam int WORD_W = BANKS * SPLIT * D_WIDTH;
  localparam int IDX_W  = $clog2(SPLIT);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PAR   = 2'd1,
    S_SER   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                w_accept;
  logic                w_fire;
  logic                w_last;
  logic [BANKS*D_WIDTH-1:0] w_ser;

  assign w_last   = (state_q == S_PAR) || ((state_q == S_SER) && (idx_q == '0));
  assign w_fire   = (state_q != S_EMPTY) && out_ready;
  assign in_ready = !rst && ((state_q == S_EMPTY) || (w_fire && w_last));
  assign w_accept = in_valid && in_ready;

  // Each bank slice is viewed as an array of sub-words so idx selects one lane.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [SPLIT-1:0][D_WIDTH-1:0] w_subs;
    assign w_subs = word_q[b*SPLIT*D_WIDTH +: SPLIT*D_WIDTH];
    assign w_ser[b*D_WIDTH +: D_WIDTH] = w_subs[idx_q];
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    if (w_accept) begin
      word_d = in_data;
      if (mode) begin
        state_d = S_SER;
        idx_d   = IDX_W'(SPLIT - 1);
      end else begin
        state_d = S_PAR;
        idx_d   = '0;
      end
    end else if (w_fire) begin
      if ((state_q == S_SER) && (idx_q != '0)) begin
        idx_d = idx_q - IDX_W'(1);
      end else begin
        state_d = S_EMPTY;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    out_last  = w_last;
    out_par   = (state_q == S_PAR) ? word_q : '0;
    out_ser   = (state_q == S_SER) ? w_ser : '0;
    out_idx   = (state_q == S_SER) ? idx_q : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_word_splitter_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_word_splitter_pipe
// Brief   : Directed scenarios plus randomized traffic against a beat-queue model.
// Revision: 1.0
// ============================================================================
module tb_rom_word_splitter_pipe;

  localparam int BANKS   = 2;
  localparam int D_WIDTH = 8;
  localparam int SPLIT   = 2;
  localparam int WW      = BANKS * SPLIT * D_WIDTH;
  localparam int SW      = BANKS * D_WIDTH;
  localparam int IW      = $clog2(SPLIT);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_par;
  logic [SW-1:0] out_ser;
  logic [IW-1:0] out_idx;
  logic          out_last;

  int n_checks = 0;
  int n_fail   = 0;

  // {in_ready, out_valid, out_last, out_idx, out_ser, out_par}
  logic [51:0] obs;
  assign obs = {in_ready, out_valid, out_last, out_idx, out_ser, out_par};

  typedef struct packed {
    logic [WW-1:0] par;
    logic [SW-1:0] ser;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t q[$];

  rom_word_splitter_pipe #(
    .BANKS(BANKS), .D_WIDTH(D_WIDTH), .SPLIT(SPLIT)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_par(out_par), .out_ser(out_ser), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic m, input logic [WW-1:0] d, input logic r);
    in_valid  = v;
    mode      = m;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    #2;
    n_checks++;
    if (obs !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected %h", obs, 52'h0);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 51'h0}) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", obs, {1'b1, 51'h0});
    end
    next_cycle();
  endtask

  task automatic test_parallel_single();
    drive(1'b1, 1'b0, 32'hA1B2C3D4, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 51'h0}) begin
      n_fail++;
      $display("FAIL par_accept: got %h expected %h", obs, {1'b1, 51'h0});
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'hA1B2C3D4}) begin
      n_fail++;
      $display("FAIL par_beat: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'hA1B2C3D4});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 51'h0}) begin
      n_fail++;
      $display("FAIL par_empty: got %h expected %h", obs, {1'b1, 51'h0});
    end
    next_cycle();
  endtask

  task automatic test_serial_single();
    drive(1'b1, 1'b1, 32'hA1B2C3D4, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h99999999, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0}) begin
      n_fail++;
      $display("FAIL ser_beat1: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0});
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'hB2D4, 32'h0}) begin
      n_fail++;
      $display("FAIL ser_beat2: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'hB2D4, 32'h0});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 51'h0}) begin
      n_fail++;
      $display("FAIL ser_empty: got %h expected %h", obs, {1'b1, 51'h0});
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) drive(1'b1, 1'b0, WW'(i), 1'b1);
      else        drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (i == 1) begin
        if (obs !== {1'b1, 51'h0}) begin
          n_fail++;
          $display("FAIL b2b_first: got %h expected %h", obs, {1'b1, 51'h0});
        end
      end else if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'(i - 1)}) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got %h expected %h", i - 1, obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'(i - 1)});
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b1, 32'hA1B2C3D4, 1'b0);
    next_cycle();
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, s[0], 32'h12345678 + 32'(s), 1'b0);
      @(negedge clk);
      n_checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h expected %h", s, obs, {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0});
      end
      next_cycle();
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0}) begin
      n_fail++;
      $display("FAIL stall_beat1: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'hB2D4, 32'h0}) begin
      n_fail++;
      $display("FAIL stall_beat2: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'hB2D4, 32'h0});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_serial();
    drive(1'b1, 1'b1, 32'hA1B2C3D4, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_beat1: got %h expected %h", obs, {1'b0, 1'b1, 1'b0, 1'b1, 16'hA1C3, 32'h0});
    end
    next_cycle();
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 52'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h expected %h", obs, 52'h0);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h11223344, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 51'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_release: got %h expected %h", obs, {1'b1, 51'h0});
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'h11223344}) begin
      n_fail++;
      $display("FAIL rst_mid_newword: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'h11223344});
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 51'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_noreplay: got %h expected %h", obs, {1'b1, 51'h0});
    end
    next_cycle();
  endtask

  task automatic test_handoff();
    drive(1'b1, 1'b1, 32'hA1B2C3D4, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h55667788, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'hB2D4, 32'h0}) begin
      n_fail++;
      $display("FAIL handoff_last: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'hB2D4, 32'h0});
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'h55667788}) begin
      n_fail++;
      $display("FAIL handoff_par: got %h expected %h", obs, {1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 32'h55667788});
    end
    next_cycle();
  endtask

  // Model: the held word is a queue of the beats it still owes downstream.
  task automatic test_random();
    beat_t       bt;
    logic        exp_ready;
    logic [51:0] exp;
    for (int c = 0; c < 600; c++) begin
      if (c < 580) drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), WW'($urandom), ($urandom_range(0, 9) < 7));
      else         drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      exp_ready = (q.size() == 0) || (out_ready && q.size() == 1);
      if (q.size() != 0) exp = {exp_ready, 1'b1, q[0].last, q[0].idx, q[0].ser, q[0].par};
      else               exp = {exp_ready, 51'h0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, obs, exp);
      end
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        if (!mode) begin
          bt.par = in_data; bt.ser = '0; bt.idx = '0; bt.last = 1'b1;
          q.push_back(bt);
        end else begin
          for (int k = SPLIT - 1; k >= 0; k--) begin
            bt.par = '0;
            for (int b = 0; b < BANKS; b++)
              bt.ser[b*D_WIDTH +: D_WIDTH] = in_data[b*SPLIT*D_WIDTH + k*D_WIDTH +: D_WIDTH];
            bt.idx  = IW'(k);
            bt.last = (k == 0);
            q.push_back(bt);
          end
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_parallel_single();
    test_serial_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_serial();
    test_handoff();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
